// File: rtl/regs_wb_arbiter_if.sv
// Writeback bus between the requesters (master) and the register-file write arbiter (slave).
interface regs_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 3
);
  logic                    hold;
  logic [NUM_REQ-1:0]      req_valid;
  logic [5*NUM_REQ-1:0]    req_rd_addr;
  logic [32*NUM_REQ-1:0]   req_rd_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic [4:0]              rd_addr;
  logic [31:0]             rd_data;
  logic                    write_en;
  logic [IDX_W-1:0]        grant_idx;
  logic                    busy;

  modport master (
    output hold, req_valid, req_rd_addr, req_rd_data,
    input  req_ready, rd_addr, rd_data, write_en, grant_idx, busy
  );

  modport slave (
    input  hold, req_valid, req_rd_addr, req_rd_data,
    output req_ready, rd_addr, rd_data, write_en, grant_idx, busy
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the single regfile write port, one grant per cycle.
// Define WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (requester 0 highest).
module regs_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  regs_wb_arbiter_if.slave  bus
);

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  logic [4:0]         sel_addr;
  logic [31:0]        sel_data;

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0]   rr_ptr;
`endif

  always_comb begin
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (i_rst_n && !bus.hold) begin
`ifdef WB_ARB_RR_EN
      // First pass covers pointer..NUM_REQ-1; the unconditioned pass below supplies the wrap.
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_found && bus.req_valid[j] && (IDX_W'(j) >= rr_ptr)) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
`endif
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_found && bus.req_valid[j]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (win_found && (win_idx == IDX_W'(j))) begin
          grant[j] = 1'b1;
          sel_addr = bus.req_rd_addr[5*j +: 5];
          sel_data = bus.req_rd_data[32*j +: 32];
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.busy      = (|bus.req_valid) & ~(|grant);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bus.rd_addr   <= '0;
      bus.rd_data   <= '0;
      bus.write_en  <= 1'b0;
      bus.grant_idx <= '0;
    end else begin
      bus.write_en <= 1'b0;
      if (win_found) begin
        bus.rd_addr   <= sel_addr;
        bus.rd_data   <= sel_data;
        bus.grant_idx <= win_idx;
        // x0 is hardwired: the slot is consumed but nothing is written.
        bus.write_en  <= (sel_addr != 5'd0);
      end
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
    end else if (win_found) begin
      rr_ptr <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Randomized scoreboard bench for regs_wb_arbiter; checks both arbitration modes (WB_ARB_RR_EN).
module tb_regs_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 3;

  typedef struct {
    int          idx;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regs_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  regs_wb_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [NUM_REQ-1:0] req_valid;
  logic [4:0]         req_addr [NUM_REQ];
  logic [31:0]        req_data [NUM_REQ];

  assign bus.req_valid = req_valid;
  always_comb begin
    bus.req_rd_addr = '0;
    bus.req_rd_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.req_rd_addr[5*k +: 5]   = req_addr[k];
      bus.req_rd_data[32*k +: 32] = req_data[k];
    end
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr = 0;
  bit          rst_chk = 0;
  wr_t         exp_q [$];
  logic [31:0] ref_rf [32];
  logic [31:0] dut_rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: pick a winner straight from the rules.
  function automatic int model_pick();
    if (!rst_n || bus.hold) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef WB_ARB_RR_EN
      int k = (m_ptr + i) % NUM_REQ;
`else
      int k = i;
`endif
      if (req_valid[k]) return k;
    end
    return -1;
  endfunction

  // One clock: check grant outputs, predict the registered write, retire the winner.
  task automatic cycle(output int acc, output logic [NUM_REQ-1:0] rdy);
    logic [NUM_REQ-1:0] exp_rdy;
    logic               exp_busy;
    @(negedge clk);
    acc      = model_pick();
    exp_rdy  = (acc >= 0) ? (NUM_REQ'(1) << acc) : '0;
    exp_busy = (|req_valid) && (acc < 0);
    rdy      = bus.req_ready;
    chk("req_ready", 64'(rdy), 64'(exp_rdy));
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    if (rst_chk) begin
      chk("rst_write_en", 64'(bus.write_en), 64'(0));
      chk("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
      chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
      chk("rst_grant_idx", 64'(bus.grant_idx), 64'(0));
      rst_chk = 0;
    end
    if (acc >= 0) begin
      if (req_addr[acc] != 5'd0) begin
        exp_q.push_back('{idx: acc, addr: req_addr[acc], data: req_data[acc]});
        ref_rf[req_addr[acc]] = req_data[acc];
      end
      m_ptr = (acc + 1) % NUM_REQ;
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ptr   = 0;
      rst_chk = 1;
    end
    #1;
    if (acc >= 0) req_valid[acc] = 1'b0;
  endtask

  task automatic load(input int k, input logic [4:0] a, input logic [31:0] d);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    req_data[k]  = d;
  endtask

  // Monitor: every registered write must match the oldest predicted write.
  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_write: got addr=%0d data=0x%0h, expected no write at %0t",
                 bus.rd_addr, bus.rd_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.rd_addr !== e.addr || bus.rd_data !== e.data || bus.grant_idx !== IDX_W'(e.idx)) begin
          n_err++;
          $display("FAIL write: got idx=%0d addr=%0d data=0x%0h expected idx=%0d addr=%0d data=0x%0h",
                   bus.grant_idx, bus.rd_addr, bus.rd_data, e.idx, e.addr, e.data);
        end
      end
      dut_rf[bus.rd_addr] = bus.rd_data;
    end
  end

  initial begin
    int                 acc;
    logic [NUM_REQ-1:0] rdy;
    int                 order [6];
    int                 guard;

    for (int r = 0; r < 32; r++) begin
      ref_rf[r] = '0;
      dut_rf[r] = '0;
    end
    rst_n    = 1'b0;
    bus.hold = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) load(k, 5'(k + 1), 32'h100 + 32'(k));

    // Reset held with every requester valid.
    cycle(acc, rdy);
    cycle(acc, rdy);
    cycle(acc, rdy);
    rst_n = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) req_valid[k] = 1'b0;
    cycle(acc, rdy);

    // Single requester, write appears one cycle after accept.
    load(1, 5'd5, 32'hDEADBEEF);
    cycle(acc, rdy);
    chk("t2_ready", 64'(rdy), 64'(3'b010));
    chk("t2_we", 64'(bus.write_en), 64'(1));
    chk("t2_addr", 64'(bus.rd_addr), 64'(5));
    chk("t2_data", 64'(bus.rd_data), 64'hDEADBEEF);
    chk("t2_idx", 64'(bus.grant_idx), 64'(1));
    cycle(acc, rdy);
    chk("t2_we_after", 64'(bus.write_en), 64'(0));

    // All requesters continuously valid from a fresh pointer.
    rst_n = 1'b0;
    cycle(acc, rdy);
    rst_n = 1'b1;
`ifdef WB_ARB_RR_EN
    order = '{0, 1, 2, 0, 1, 2};
`else
    order = '{0, 0, 0, 0, 0, 0};
`endif
    for (int k = 0; k < NUM_REQ; k++) load(k, 5'(10 + k), $urandom);
    for (int i = 0; i < 6; i++) begin
      cycle(acc, rdy);
      chk("t3_order", 64'(rdy), 64'(NUM_REQ'(1) << order[i]));
      if (acc >= 0) load(acc, 5'(10 + acc), $urandom);
    end
    for (int k = 0; k < NUM_REQ; k++) req_valid[k] = 1'b0;
    cycle(acc, rdy);

    // Write to x0 consumes the grant but never reaches the regfile.
    rst_n = 1'b0;
    cycle(acc, rdy);
    rst_n = 1'b1;
    load(0, 5'd0, 32'h1234);
    cycle(acc, rdy);
    chk("t4_ready", 64'(rdy), 64'(3'b001));
    chk("t4_we", 64'(bus.write_en), 64'(0));
    load(0, 5'd3, 32'hA0);
    load(1, 5'd4, 32'hB0);
    cycle(acc, rdy);
`ifdef WB_ARB_RR_EN
    chk("t4_ptr", 64'(rdy), 64'(3'b010));
`else
    chk("t4_ptr", 64'(rdy), 64'(3'b001));
`endif
    cycle(acc, rdy);
    cycle(acc, rdy);

    // Hold freezes grants, then both pending requests drain in order.
    rst_n = 1'b0;
    cycle(acc, rdy);
    rst_n = 1'b1;
    load(0, 5'd8, 32'hC0);
    load(2, 5'd9, 32'hC2);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(acc, rdy);
      chk("t5_hold_ready", 64'(rdy), 64'(0));
      chk("t5_hold_we", 64'(bus.write_en), 64'(0));
    end
    bus.hold = 1'b0;
    cycle(acc, rdy);
    chk("t5_first", 64'(rdy), 64'(3'b001));
    cycle(acc, rdy);
    chk("t5_second", 64'(rdy), 64'(3'b100));

    // Two writes to x7, then reset in the middle of a stream.
    load(0, 5'd7, 32'hAAAA_0007);
    load(1, 5'd7, 32'hBBBB_0007);
    cycle(acc, rdy);
    cycle(acc, rdy);
    cycle(acc, rdy);
    chk("t6_x7", 64'(dut_rf[7]), 64'(ref_rf[7]));
    for (int k = 0; k < NUM_REQ; k++) load(k, 5'(20 + k), $urandom);
    cycle(acc, rdy);
    rst_n = 1'b0;
    cycle(acc, rdy);
    chk("t6_rst_we", 64'(bus.write_en), 64'(0));
    rst_n = 1'b1;

    // Randomized traffic with holds, x0 writes and occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req_valid[k] && ($urandom_range(0, 1) == 1))
          load(k, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      end
      bus.hold = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 63) != 0);
      cycle(acc, rdy);
    end

    // Drain and compare the regfile images.
    rst_n    = 1'b1;
    bus.hold = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) req_valid[k] = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      cycle(acc, rdy);
      guard++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    for (int r = 1; r < 32; r++) chk("regfile", 64'(dut_rf[r]), 64'(ref_rf[r]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
